pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, program-counter width in bits.
REQ-002 SHALL have parameter STACK_DEPTH, default 4, return-address stack entries (>=2).
REQ-003 SHALL have parameter RESET_VEC, default 0, value loaded into pc_out on reset.
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port en  input  1  global advance enable; low = hold all state.
REQ-007 SHALL have port load_pc  input  1  jump to target.
REQ-008 SHALL have port call  input  1  push return address, jump to target.
REQ-009 SHALL have port ret  input  1  pop stack into pc_out.
REQ-010 SHALL have port skip  input  1  advance by 2.
REQ-011 SHALL have port inc_pc  input  1  advance by 1.
REQ-012 SHALL have port target  input  ADDR_W  jump/call destination.
REQ-013 SHALL have port clr_err  input  1  synchronous clear of sticky error flags.
REQ-014 SHALL have port pc_out  output  ADDR_W  current program counter.
REQ-015 SHALL have port stack_empty  output  1  stack holds 0 entries.
REQ-016 SHALL have port stack_full  output  1  stack holds STACK_DEPTH entries.
REQ-017 SHALL have port ovf_err  output  1  sticky: call attempted while full.
REQ-018 SHALL have port unf_err  output  1  sticky: ret attempted while empty.

Function
REQ-019 SHALL ignore every command when en=0; pc_out, stack and flags hold, except clr_err, which still acts.
REQ-020 SHALL resolve simultaneous commands by fixed priority: ret > call > load_pc > skip > inc_pc; lower ones are dropped that cycle.
REQ-021 SHALL with no command asserted hold pc_out.
REQ-022 SHALL on inc_pc set pc_out <= pc_out+1 and on skip set pc_out <= pc_out+2, both modulo 2^ADDR_W (wrap, no flag).
REQ-023 SHALL on load_pc set pc_out <= target the next edge (1-cycle latency).
REQ-024 SHALL on call with stack not full push (pc_out+1) mod 2^ADDR_W, set pc_out <= target, increment depth.
REQ-025 SHALL on call with stack full leave pc_out and stack unchanged.
REQ-026 SHALL on ret with stack not empty set pc_out <= top entry and decrement depth.
REQ-027 SHALL on ret with stack empty leave pc_out unchanged.
REQ-028 SHALL derive stack_empty/stack_full combinationally from registered depth count (0..STACK_DEPTH).
REQ-029 SHALL give clr_err priority over a same-cycle error set (flag reads 0 after that edge).

Reset
REQ-030 SHALL on reset assertion immediately force pc_out=RESET_VEC, depth=0, stack_empty=1, stack_full=0, ovf_err=0, unf_err=0, including mid-call/ret.
REQ-031 SHALL not require stack storage entries to be reset; only depth is architectural.

Configuration
REQ-032 SHALL honour macro PC_SEQUENCER_ERR_EN: defined -> ovf_err/unf_err set per REQ-025/027 and cleared by clr_err or reset.
REQ-033 SHALL with PC_SEQUENCER_ERR_EN undefined tie ovf_err=unf_err=0, ignore clr_err, and keep REQ-025/027 drop behaviour.

Structure
REQ-034 SHALL place the command-priority enum (NONE, INC, SKIP, LOAD, CALL, RET) and the RESET_VEC default constant in shared package pc_seq_pkg.
REQ-035 SHALL implement the LIFO as sub-module pc_seq_stack (parameters ADDR_W, STACK_DEPTH; push/pop/top/empty/full).

Verification
REQ-036 Reset, then inc_pc x3 -> pc_out 0,1,2,3; with ADDR_W=8 from pc_out=8'hFF inc_pc -> 8'h00; skip from 8'hFE -> 8'h00.
REQ-037 pc_out=8'h10, call target=8'h40 -> pc_out=8'h40, stack_empty=0; then ret -> pc_out=8'h11, stack_empty=1.
REQ-038 4 nested calls (depth 4) -> stack_full=1; 5th call target=8'h99 -> pc_out unchanged, ovf_err=1; clr_err -> ovf_err=0.
REQ-039 ret on empty stack at pc_out=8'h20 -> pc_out stays 8'h20, unf_err=1 (0 when macro undefined).
REQ-040 ret+call+load_pc+inc_pc same cycle with one entry 8'h05 -> pc_out=8'h05, depth 0; en=0 with inc_pc -> pc_out holds.
REQ-041 Assert reset asynchronously between edges during a call at depth 3 -> pc_out=RESET_VEC and depth 0 before next edge.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types for the program-counter sequencer: command priority encoding
// and the default reset vector.
package pc_seq_pkg;

    typedef enum logic [2:0] {
        NONE = 3'd0,
        INC  = 3'd1,
        SKIP = 3'd2,
        LOAD = 3'd3,
        CALL = 3'd4,
        RET  = 3'd5
    } cmd_e;

    localparam int RESET_VEC_DEFAULT = 0;

    // Highest-priority command wins; en=0 suppresses everything.
    function automatic cmd_e decode_cmd(input logic en, input logic ret, input logic call,
                                        input logic load_pc, input logic skip,
                                        input logic inc_pc);
        if (!en)          return NONE;
        else if (ret)     return RET;
        else if (call)    return CALL;
        else if (load_pc) return LOAD;
        else if (skip)    return SKIP;
        else if (inc_pc)  return INC;
        else              return NONE;
    endfunction

endpackage

// File: rtl/pc_seq_stack.sv
// Return-address LIFO. Only the depth count is reset; entry storage is not.
module pc_seq_stack
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [DW-1:0]     depth;
    logic [ADDR_W-1:0] mem [STACK_DEPTH];

    assign empty = (depth == '0);
    assign full  = (depth == DW'(STACK_DEPTH));
    assign top   = mem[IW'(depth - DW'(1))];

    // Callers guarantee push/pop are exclusive and never push-full / pop-empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            depth <= '0;
        else if (push)
            depth <= depth + DW'(1);
        else if (pop)
            depth <= depth - DW'(1);
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[IW'(depth)] <= push_data;
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter with call/return stack and fixed command priority.
// Optional sticky overflow/underflow flags under `define PC_SEQUENCER_ERR_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int              ADDR_W      = 8,
    parameter int              STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEFAULT)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              load_pc,
    input  logic              call,
    input  logic              ret,
    input  logic              skip,
    input  logic              inc_pc,
    input  logic [ADDR_W-1:0] target,
    input  logic              clr_err,
    output logic [ADDR_W-1:0] pc_out,
    output logic              stack_empty,
    output logic              stack_full,
    output logic              ovf_err,
    output logic              unf_err
);

    cmd_e              cmd;
    logic              push, pop;
    logic [ADDR_W-1:0] stack_top;

    assign cmd  = decode_cmd(en, ret, call, load_pc, skip, inc_pc);
    assign push = (cmd == CALL) && !stack_full;
    assign pop  = (cmd == RET)  && !stack_empty;

    pc_seq_stack #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_out + ADDR_W'(1)),
        .top       (stack_top),
        .empty     (stack_empty),
        .full      (stack_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_out <= RESET_VEC;
        end else begin
            case (cmd)
                INC:  pc_out <= pc_out + ADDR_W'(1);
                SKIP: pc_out <= pc_out + ADDR_W'(2);
                LOAD: pc_out <= target;
                CALL: if (push) pc_out <= target;
                RET:  if (pop)  pc_out <= stack_top;
                default: ;
            endcase
        end
    end

`ifdef PC_SEQUENCER_ERR_EN
    // clr_err bypasses en and beats a same-cycle set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else if (clr_err) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (cmd == CALL && stack_full)  ovf_err <= 1'b1;
            if (cmd == RET  && stack_empty) unf_err <= 1'b1;
        end
    end
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign ovf_err = 1'b0;
    assign unf_err = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer (ADDR_W=8, STACK_DEPTH=4, RESET_VEC=0).
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset, en, load_pc, call, ret, skip, inc_pc, clr_err;
    logic [7:0] target, pc_out;
    logic       stack_empty, stack_full, ovf_err, unf_err;

    int n_chk  = 0;
    int n_pass = 0;

`ifdef PC_SEQUENCER_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    pc_sequencer #(.ADDR_W(8), .STACK_DEPTH(4), .RESET_VEC(8'h00)) dut (
        .clk(clk), .reset(reset), .en(en), .load_pc(load_pc), .call(call), .ret(ret),
        .skip(skip), .inc_pc(inc_pc), .target(target), .clr_err(clr_err),
        .pc_out(pc_out), .stack_empty(stack_empty), .stack_full(stack_full),
        .ovf_err(ovf_err), .unf_err(unf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Apply one cycle of command inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic r, input logic c, input logic l, input logic s,
                       input logic i, input logic [7:0] t);
        ret = r; call = c; load_pc = l; skip = s; inc_pc = i; target = t;
        @(posedge clk); #1;
        ret = 0; call = 0; load_pc = 0; skip = 0; inc_pc = 0; clr_err = 0; en = 1;
    endtask

    initial begin
        reset = 1; en = 1; load_pc = 0; call = 0; ret = 0; skip = 0; inc_pc = 0;
        clr_err = 0; target = 8'h00;
        #12;
        chk("rst_pc", pc_out, 8'h00);
        chk("rst_empty", stack_empty, 1);
        chk("rst_full", stack_full, 0);
        chk("rst_ovf", ovf_err, 0);
        chk("rst_unf", unf_err, 0);
        @(negedge clk); reset = 0;

        cyc(0,0,0,0,1,0); chk("inc1", pc_out, 8'h01);
        cyc(0,0,0,0,1,0); chk("inc2", pc_out, 8'h02);
        cyc(0,0,0,0,1,0); chk("inc3", pc_out, 8'h03);
        cyc(0,0,0,0,0,0); chk("hold", pc_out, 8'h03);
        cyc(0,0,1,0,0,8'hFF); chk("load_ff", pc_out, 8'hFF);
        cyc(0,0,0,0,1,0); chk("inc_wrap", pc_out, 8'h00);
        cyc(0,0,1,0,0,8'hFE);
        cyc(0,0,0,1,0,0); chk("skip_wrap", pc_out, 8'h00);

        cyc(0,0,1,0,0,8'h10);
        cyc(0,1,0,0,0,8'h40); chk("call_pc", pc_out, 8'h40);
        chk("call_nempty", stack_empty, 0);
        cyc(1,0,0,0,0,0); chk("ret_pc", pc_out, 8'h11);
        chk("ret_empty", stack_empty, 1);

        // Nested calls from 0x10: pushes 11, 21, 31, 41
        cyc(0,0,1,0,0,8'h10);
        cyc(0,1,0,0,0,8'h20);
        cyc(0,1,0,0,0,8'h30);
        cyc(0,1,0,0,0,8'h40); chk("d3_nfull", stack_full, 0);
        cyc(0,1,0,0,0,8'h50); chk("d4_full", stack_full, 1);
        cyc(0,1,0,0,0,8'h99); chk("ovf_pc", pc_out, 8'h50);
        chk("ovf_err", ovf_err, ERR);
        clr_err = 1;
        cyc(0,0,0,0,0,0); chk("ovf_clr", ovf_err, 0);
        cyc(1,0,0,0,0,0); chk("pop4", pc_out, 8'h41);
        chk("pop4_nfull", stack_full, 0);
        cyc(1,0,0,0,0,0); chk("pop3", pc_out, 8'h31);
        cyc(1,0,0,0,0,0); chk("pop2", pc_out, 8'h21);
        cyc(1,0,0,0,0,0); chk("pop1", pc_out, 8'h11);
        chk("pop_empty", stack_empty, 1);

        cyc(0,0,1,0,0,8'h20);
        cyc(1,0,0,0,0,0); chk("unf_pc", pc_out, 8'h20);
        chk("unf_err", unf_err, ERR);
        chk("unf_empty", stack_empty, 1);
        clr_err = 1;
        cyc(1,0,0,0,0,0); chk("clr_beats_set", unf_err, 0);

        // One entry 0x05, then all commands at once: ret wins.
        cyc(0,0,1,0,0,8'h04);
        cyc(0,1,0,0,0,8'h70); chk("one_call", pc_out, 8'h70);
        ret = 1; call = 1; load_pc = 1; inc_pc = 1; target = 8'h80;
        @(posedge clk); #1;
        ret = 0; call = 0; load_pc = 0; inc_pc = 0;
        chk("prio_pc", pc_out, 8'h05);
        chk("prio_empty", stack_empty, 1);

        en = 0;
        cyc(0,0,0,0,1,0); chk("en0_inc", pc_out, 8'h05);
        en = 0;
        cyc(0,1,0,0,0,8'h33); chk("en0_call_pc", pc_out, 8'h05);
        chk("en0_call_empty", stack_empty, 1);
        en = 0;
        cyc(1,0,0,0,0,0); chk("en0_ret_unf", unf_err, 0);

        cyc(1,0,0,0,0,0); chk("unf_again", unf_err, ERR);
        en = 0; clr_err = 1;
        cyc(0,0,0,0,0,0); chk("en0_clr", unf_err, 0);

        // Depth 3, then reset asserted between edges while a call is pending.
        cyc(0,0,1,0,0,8'h00);
        cyc(0,1,0,0,0,8'h10);
        cyc(0,1,0,0,0,8'h20);
        cyc(0,1,0,0,0,8'h30); chk("d3_pc", pc_out, 8'h30);
        call = 1; target = 8'h90;
        @(negedge clk); reset = 1; #1;
        chk("async_pc", pc_out, 8'h00);
        chk("async_empty", stack_empty, 1);
        chk("async_full", stack_full, 0);
        @(posedge clk); #1;
        chk("rst_hold_pc", pc_out, 8'h00);
        call = 0;
        @(negedge clk); reset = 0;
        cyc(1,0,0,0,0,0); chk("post_rst_ret", pc_out, 8'h00);
        chk("post_rst_unf", unf_err, ERR);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
